data_register_bank: RTL and testbench
=====================================

# data_register_bank

Parametrised register bank for the bb_core datapath. It holds the address register (AR), NUM_DR data registers and the program counter (PC), with a hardware return-address stack for call and return. Operand, memory-address and bus read-out paths are selected by index. It sits between the instruction decoder (selects and enables) and the ALU and memory interface (operands and addresses).

## Interface
Parameters:
- DATA_WIDTH, 16, width of every register and data port
- NUM_DR, 4, number of data registers (min 2)
- STACK_DEPTH, 4, return-address stack entries (min 1)
- SEL_W, $clog2(NUM_DR+2), register index width (derived)
- CNT_W, $clog2(STACK_DEPTH+1), stack count width (derived)

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- i_data  in  DATA_WIDTH  write, jump and call-target data
- i_wr_en  in  1  write i_data into register i_wr_sel
- i_wr_sel  in  SEL_W  write index
- i_rd_sel  in  SEL_W  index driven onto o_register_output
- i_op0_sel, i_op1_sel  in  SEL_W  operand indices
- i_ar_inc  in  1  post-increment AR
- i_pc_counter_en  in  1  PC <= PC+1
- i_pc_call  in  1  push PC+1, PC <= i_data
- i_pc_ret  in  1  PC <= top of stack, pop
- i_mem_addr_source  in  1  1: o_mem_addr = PC; 0: o_mem_addr = AR
- i_err_clr  in  1  clear o_stack_err
- o_register_output, o_operand0, o_operand1  out  DATA_WIDTH  selected register values
- o_direct_addr  out  DATA_WIDTH  AR
- o_mem_addr  out  DATA_WIDTH  PC or AR, per i_mem_addr_source
- o_program_addr  out  DATA_WIDTH  PC
- o_stack_count  out  CNT_W  valid stack entries
- o_stack_full, o_stack_empty  out  1  count == STACK_DEPTH / count == 0
- o_stack_err  out  1  sticky overflow/underflow/conflict flag

## Operation
- Index map:
  - 0 = AR
  - 1..NUM_DR = DR0..DR(NUM_DR-1)
  - NUM_DR+1 = PC
  - Higher indices: writes are ignored; reads return 0.
- Read paths are combinational from register state. There is no write bypass: a read in the same cycle as a write returns the old value.
- DR: loads i_data when i_wr_en and its index is selected; otherwise holds.
- AR priority:
  - write > i_ar_inc > hold
  - Increment is modulo 2^DATA_WIDTH, so FFFF -> 0000 at width 16.
- PC priority, highest first:
  1. call and ret together: conflict. PC holds, stack is unchanged, err is set.
  2. ret, stack non-empty: PC <= top, count-1.
  3. ret, stack empty: underflow. PC holds, err is set.
  4. call, stack not full: stack[count] <= PC+1, count+1, PC <= i_data.
  5. call, stack full: overflow. PC <= i_data, push is dropped, stack is unchanged, err is set.
  6. write to index NUM_DR+1: PC <= i_data.
  7. i_pc_counter_en: PC <= PC+1, wrapping.
  8. Otherwise PC holds.
- Any higher-priority PC event masks the lower ones in that cycle.
- The pushed value is PC+1 computed modulo 2^DATA_WIDTH.
- Stack is LIFO, implemented as a register array indexed by count; top = stack[count-1].
- o_stack_err behaviour:
  - Set by any overflow, underflow or conflict.
  - Cleared by i_err_clr.
  - If set and clear occur in the same cycle, set wins.

## Timing
- Reset (rst_n low, async):
  - AR, all DRs, PC, stack entries and count go to 0; err goes to 0.
  - Outputs therefore read 0, except o_stack_empty = 1 and o_stack_full = 0.
- Every register update has a latency of one clock; the new value is visible on outputs immediately after the edge.
- o_stack_count, o_stack_full and o_stack_empty are combinational from count, so they reflect a push or pop one cycle after it.
- Call followed by ret on consecutive cycles is legal.
- Back-to-back pushes up to STACK_DEPTH are legal without stalls.
- Reset asserted mid-sequence clears state immediately, regardless of clk. The first edge after rst_n rises performs normal operation.

## Test plan
- Reset and index map: reset -> all outputs 0, empty = 1.
  - Write 0x1111 to DR0 (idx 1) and 0x2222 to DR3 (idx 4), then op0_sel = 1, op1_sel = 4 -> 0x1111 and 0x2222.
  - Read idx 7 -> 0.
  - Write idx 6 -> no register changes.
- AR increment: write AR = 0xFFFE, then ar_inc for 2 cycles -> 0xFFFF, 0x0000.
  - wr_en(AR, 0x0010) together with ar_inc -> 0x0010.
  - mem_addr_source = 0 -> o_mem_addr = AR.
- Call/return: PC = 0x0005, call with i_data = 0x0100 -> PC = 0x0100, count = 1.
  - Counter_en for 3 cycles -> 0x0103.
  - ret -> PC = 0x0006, count = 0.
- Stack overflow: starting empty, 5 calls with STACK_DEPTH = 4 -> full = 1 after the 4th call, err = 1 after the 5th, PC = 5th target.
  - 4 rets return the pushed addresses in reverse order.
  - 5th ret -> underflow, PC holds.
- Conflicts and flags:
  - call + ret together -> PC and count unchanged, err = 1.
  - err_clr -> err = 0.
  - err_clr together with an underflow -> err stays 1.
  - ret + counter_en with a non-empty stack -> PC = popped value.
- Async reset mid-operation: with count = 2 and PC = 0x0200, drop rst_n between clock edges -> PC = 0 and count = 0 immediately, before the next edge.

Source files
------------

// File: rtl/data_register_bank_if.sv
// rtl/data_register_bank_if.sv - decoder/datapath bundle for the data register bank
interface data_register_bank_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_DR      = 4,
  parameter int STACK_DEPTH = 4,
  parameter int SEL_W       = $clog2(NUM_DR + 2),
  parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_wr_en;
  logic [SEL_W-1:0]      i_wr_sel;
  logic [SEL_W-1:0]      i_rd_sel;
  logic [SEL_W-1:0]      i_op0_sel;
  logic [SEL_W-1:0]      i_op1_sel;
  logic                  i_ar_inc;
  logic                  i_pc_counter_en;
  logic                  i_pc_call;
  logic                  i_pc_ret;
  logic                  i_mem_addr_source;
  logic                  i_err_clr;
  logic [DATA_WIDTH-1:0] o_register_output;
  logic [DATA_WIDTH-1:0] o_operand0;
  logic [DATA_WIDTH-1:0] o_operand1;
  logic [DATA_WIDTH-1:0] o_direct_addr;
  logic [DATA_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_program_addr;
  logic [CNT_W-1:0]      o_stack_count;
  logic                  o_stack_full;
  logic                  o_stack_empty;
  logic                  o_stack_err;

  // Decoder side: drives selects/enables, observes register values
  modport master (
    output i_data, i_wr_en, i_wr_sel, i_rd_sel, i_op0_sel, i_op1_sel,
    output i_ar_inc, i_pc_counter_en, i_pc_call, i_pc_ret, i_mem_addr_source, i_err_clr,
    input  o_register_output, o_operand0, o_operand1, o_direct_addr, o_mem_addr,
    input  o_program_addr, o_stack_count, o_stack_full, o_stack_empty, o_stack_err
  );

  // Register bank side
  modport slave (
    input  i_data, i_wr_en, i_wr_sel, i_rd_sel, i_op0_sel, i_op1_sel,
    input  i_ar_inc, i_pc_counter_en, i_pc_call, i_pc_ret, i_mem_addr_source, i_err_clr,
    output o_register_output, o_operand0, o_operand1, o_direct_addr, o_mem_addr,
    output o_program_addr, o_stack_count, o_stack_full, o_stack_empty, o_stack_err
  );
endinterface

// File: rtl/data_register_bank.sv
// rtl/data_register_bank.sv - AR, data registers, PC and return-address stack
module data_register_bank #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_DR      = 4,
  parameter int STACK_DEPTH = 4,
  parameter int SEL_W       = $clog2(NUM_DR + 2),
  parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_register_bank_if.slave   bus
);
  localparam logic [SEL_W-1:0] AR_IDX = '0;
  localparam logic [SEL_W-1:0] PC_IDX = SEL_W'(NUM_DR + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

  logic [DATA_WIDTH-1:0] ar_q, ar_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] dr_q  [NUM_DR];
  logic [DATA_WIDTH-1:0] dr_d  [NUM_DR];
  logic [DATA_WIDTH-1:0] stk_q [STACK_DEPTH];
  logic [DATA_WIDTH-1:0] stk_d [STACK_DEPTH];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] view [NUM_DR + 2];
  logic [DATA_WIDTH-1:0] rd_val, op0_val, op1_val;
  logic [DATA_WIDTH-1:0] stk_top;
  logic [DATA_WIDTH-1:0] pc_inc;
  logic                  stk_empty, stk_full;
  logic                  set_err;

  assign stk_empty = (cnt_q == '0);
  assign stk_full  = (cnt_q == FULL_CNT);
  assign pc_inc    = pc_q + 1'b1;

  // Flatten the index map: AR, DR0..DRn-1, PC
  always_comb begin
    view[0] = ar_q;
    for (int i = 0; i < NUM_DR; i++) view[i + 1] = dr_q[i];
    view[NUM_DR + 1] = pc_q;
  end

  // Index-selected read paths; indices past PC read as zero, no write bypass
  always_comb begin
    rd_val  = '0;
    op0_val = '0;
    op1_val = '0;
    for (int i = 0; i < NUM_DR + 2; i++) begin
      if (bus.i_rd_sel  == SEL_W'(i)) rd_val  = view[i];
      if (bus.i_op0_sel == SEL_W'(i)) op0_val = view[i];
      if (bus.i_op1_sel == SEL_W'(i)) op1_val = view[i];
    end
  end

  // Top of stack is the entry just below count; empty stack reads zero
  always_comb begin
    stk_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (cnt_q == CNT_W'(i + 1)) stk_top = stk_q[i];
  end

  // AR and DR next state: write beats increment beats hold
  always_comb begin
    ar_d = ar_q;
    if (bus.i_wr_en && bus.i_wr_sel == AR_IDX) ar_d = bus.i_data;
    else if (bus.i_ar_inc)                     ar_d = ar_q + 1'b1;
    for (int i = 0; i < NUM_DR; i++) begin
      dr_d[i] = dr_q[i];
      if (bus.i_wr_en && bus.i_wr_sel == SEL_W'(i + 1)) dr_d[i] = bus.i_data;
    end
  end

  // PC and stack next state in strict priority; faults set the sticky error
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    stk_d   = stk_q;
    set_err = 1'b0;
    if (bus.i_pc_call && bus.i_pc_ret) begin
      set_err = 1'b1;
    end else if (bus.i_pc_ret) begin
      if (!stk_empty) begin
        pc_d  = stk_top;
        cnt_d = cnt_q - 1'b1;
      end else begin
        set_err = 1'b1;
      end
    end else if (bus.i_pc_call) begin
      // The jump happens even when the push has to be dropped
      pc_d = bus.i_data;
      if (!stk_full) begin
        for (int i = 0; i < STACK_DEPTH; i++)
          if (cnt_q == CNT_W'(i)) stk_d[i] = pc_inc;
        cnt_d = cnt_q + 1'b1;
      end else begin
        set_err = 1'b1;
      end
    end else if (bus.i_wr_en && bus.i_wr_sel == PC_IDX) begin
      pc_d = bus.i_data;
    end else if (bus.i_pc_counter_en) begin
      pc_d = pc_inc;
    end
    err_d = set_err ? 1'b1 : (bus.i_err_clr ? 1'b0 : err_q);
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q  <= '0;
      pc_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NUM_DR; i++)      dr_q[i]  <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      ar_q  <= ar_d;
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      for (int i = 0; i < NUM_DR; i++)      dr_q[i]  <= dr_d[i];
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= stk_d[i];
    end
  end

  assign bus.o_register_output = rd_val;
  assign bus.o_operand0        = op0_val;
  assign bus.o_operand1        = op1_val;
  assign bus.o_direct_addr     = ar_q;
  assign bus.o_mem_addr        = bus.i_mem_addr_source ? pc_q : ar_q;
  assign bus.o_program_addr    = pc_q;
  assign bus.o_stack_count     = cnt_q;
  assign bus.o_stack_full      = stk_full;
  assign bus.o_stack_empty     = stk_empty;
  assign bus.o_stack_err       = err_q;
endmodule

// File: tb/tb_data_register_bank.sv
// tb/tb_data_register_bank.sv - vector table plus scoreboard bench for data_register_bank
module tb_data_register_bank;
  localparam int DW = 16, NDR = 4, SD = 4, SW = 3, CW = 3;

  localparam logic [6:0] WR = 7'd1, AI = 7'd2, PE = 7'd4, CL = 7'd8;
  localparam logic [6:0] RT = 7'd16, SRC = 7'd32, EC = 7'd64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_register_bank_if #(.DATA_WIDTH(DW), .NUM_DR(NDR), .STACK_DEPTH(SD),
                          .SEL_W(SW), .CNT_W(CW)) bus();

  data_register_bank #(.DATA_WIDTH(DW), .NUM_DR(NDR), .STACK_DEPTH(SD),
                       .SEL_W(SW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [6:0]  ctl;
    logic [2:0]  wsel;
    logic [15:0] data;
    logic [2:0]  rsel, s0, s1;
    logic [15:0] e_rd, e_op0, e_op1, e_ar, e_pc;
    logic [2:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic [6:0] ctl, input int ws, input logic [15:0] d,
                              input int rs, input int a, input int b,
                              input logic [15:0] erd, input logic [15:0] eo0, input logic [15:0] eo1,
                              input logic [15:0] ear, input logic [15:0] epc,
                              input int ecnt, input logic eerr);
    vec_t v;
    v.ctl = ctl; v.wsel = 3'(ws); v.data = d;
    v.rsel = 3'(rs); v.s0 = 3'(a); v.s1 = 3'(b);
    v.e_rd = erd; v.e_op0 = eo0; v.e_op1 = eo1; v.e_ar = ear; v.e_pc = epc;
    v.e_cnt = 3'(ecnt); v.e_err = eerr;
    return v;
  endfunction

  // PC/stack section: AR fixed at 0x0010, rd/op0 on AR, op1 on PC, mem addr from PC
  function automatic vec_t mkp(input logic [6:0] ctl, input int ws, input logic [15:0] d,
                               input logic [15:0] epc, input int ecnt, input logic eerr);
    return mk(ctl | SRC, ws, d, 0, 0, 5, 16'h0010, 16'h0010, epc, 16'h0010, epc, ecnt, eerr);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_wr_en           = v.ctl[0];
    bus.i_ar_inc          = v.ctl[1];
    bus.i_pc_counter_en   = v.ctl[2];
    bus.i_pc_call         = v.ctl[3];
    bus.i_pc_ret          = v.ctl[4];
    bus.i_mem_addr_source = v.ctl[5];
    bus.i_err_clr         = v.ctl[6];
    bus.i_wr_sel          = v.wsel;
    bus.i_data            = v.data;
    bus.i_rd_sel          = v.rsel;
    bus.i_op0_sel         = v.s0;
    bus.i_op1_sel         = v.s1;
  endtask

  task automatic check_vec(input vec_t e, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, " rd"},    32'(bus.o_register_output), 32'(e.e_rd));
    chk({t, " op0"},   32'(bus.o_operand0), 32'(e.e_op0));
    chk({t, " op1"},   32'(bus.o_operand1), 32'(e.e_op1));
    chk({t, " ar"},    32'(bus.o_direct_addr), 32'(e.e_ar));
    chk({t, " pc"},    32'(bus.o_program_addr), 32'(e.e_pc));
    chk({t, " mem"},   32'(bus.o_mem_addr), 32'(e.ctl[5] ? e.e_pc : e.e_ar));
    chk({t, " cnt"},   32'(bus.o_stack_count), 32'(e.e_cnt));
    chk({t, " full"},  32'(bus.o_stack_full), 32'(e.e_cnt == 3'(SD)));
    chk({t, " empty"}, 32'(bus.o_stack_empty), 32'(e.e_cnt == 3'd0));
    chk({t, " err"},   32'(bus.o_stack_err), 32'(e.e_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    vec_t e;
    idle = mk(7'd0, 0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1'b0);
    drive(idle);

    // Reset state, sampled while reset is held
    #3;
    chk("rst rd",    32'(bus.o_register_output), 32'h0);
    chk("rst op0",   32'(bus.o_operand0), 32'h0);
    chk("rst op1",   32'(bus.o_operand1), 32'h0);
    chk("rst ar",    32'(bus.o_direct_addr), 32'h0);
    chk("rst mem",   32'(bus.o_mem_addr), 32'h0);
    chk("rst pc",    32'(bus.o_program_addr), 32'h0);
    chk("rst cnt",   32'(bus.o_stack_count), 32'h0);
    chk("rst full",  32'(bus.o_stack_full), 32'h0);
    chk("rst empty", 32'(bus.o_stack_empty), 32'h1);
    chk("rst err",   32'(bus.o_stack_err), 32'h0);
    #9 rst_n = 1'b1;

    // Index map and DR writes
    vecs.push_back(mk(WR, 1, 16'h1111, 0, 1, 4, 16'h0, 16'h1111, 16'h0, 16'h0, 16'h0, 0, 1'b0));
    vecs.push_back(mk(WR, 4, 16'h2222, 7, 1, 4, 16'h0, 16'h1111, 16'h2222, 16'h0, 16'h0, 0, 1'b0));
    vecs.push_back(mk(WR, 6, 16'hABCD, 1, 4, 6, 16'h1111, 16'h2222, 16'h0, 16'h0, 16'h0, 0, 1'b0));
    vecs.push_back(mk(7'd0, 0, 16'h0, 2, 3, 4, 16'h0, 16'h0, 16'h2222, 16'h0, 16'h0, 0, 1'b0));
    // AR write, increment with wrap, write beats increment
    vecs.push_back(mk(WR, 0, 16'hFFFE, 0, 0, 5, 16'hFFFE, 16'hFFFE, 16'h0, 16'hFFFE, 16'h0, 0, 1'b0));
    vecs.push_back(mk(AI, 0, 16'h0, 0, 0, 5, 16'hFFFF, 16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 0, 1'b0));
    vecs.push_back(mk(AI, 0, 16'h0, 0, 0, 5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1'b0));
    vecs.push_back(mk(WR | AI, 0, 16'h0010, 0, 0, 5, 16'h0010, 16'h0010, 16'h0, 16'h0010, 16'h0, 0, 1'b0));
    vecs.push_back(mk(WR, 5, 16'h0005, 0, 0, 5, 16'h0010, 16'h0010, 16'h0005, 16'h0010, 16'h0005, 0, 1'b0));
    // Call, count, return
    vecs.push_back(mkp(CL, 0, 16'h0100, 16'h0100, 1, 1'b0));
    vecs.push_back(mkp(PE, 0, 16'h0, 16'h0101, 1, 1'b0));
    vecs.push_back(mkp(PE, 0, 16'h0, 16'h0102, 1, 1'b0));
    vecs.push_back(mkp(PE, 0, 16'h0, 16'h0103, 1, 1'b0));
    vecs.push_back(mkp(RT, 0, 16'h0, 16'h0006, 0, 1'b0));
    // Fill the stack, overflow on the fifth call
    vecs.push_back(mkp(CL, 0, 16'h1000, 16'h1000, 1, 1'b0));
    vecs.push_back(mkp(CL, 0, 16'h2000, 16'h2000, 2, 1'b0));
    vecs.push_back(mkp(CL, 0, 16'h3000, 16'h3000, 3, 1'b0));
    vecs.push_back(mkp(CL, 0, 16'h4000, 16'h4000, 4, 1'b0));
    vecs.push_back(mkp(CL, 0, 16'h5000, 16'h5000, 4, 1'b1));
    vecs.push_back(mkp(EC, 0, 16'h0, 16'h5000, 4, 1'b0));
    // Unwind in LIFO order, then underflow
    vecs.push_back(mkp(RT, 0, 16'h0, 16'h3001, 3, 1'b0));
    vecs.push_back(mkp(RT, 0, 16'h0, 16'h2001, 2, 1'b0));
    vecs.push_back(mkp(RT, 0, 16'h0, 16'h1001, 1, 1'b0));
    vecs.push_back(mkp(RT, 0, 16'h0, 16'h0007, 0, 1'b0));
    vecs.push_back(mkp(RT, 0, 16'h0, 16'h0007, 0, 1'b1));
    vecs.push_back(mkp(EC, 0, 16'h0, 16'h0007, 0, 1'b0));
    vecs.push_back(mkp(RT | EC, 0, 16'h0, 16'h0007, 0, 1'b1));
    vecs.push_back(mkp(EC, 0, 16'h0, 16'h0007, 0, 1'b0));
    // Conflict, and ret masking the counter
    vecs.push_back(mkp(CL, 0, 16'h0300, 16'h0300, 1, 1'b0));
    vecs.push_back(mkp(CL | RT, 0, 16'h0999, 16'h0300, 1, 1'b1));
    vecs.push_back(mkp(EC, 0, 16'h0, 16'h0300, 1, 1'b0));
    vecs.push_back(mkp(RT | PE, 0, 16'h0, 16'h0008, 0, 1'b0));
    // PC write beats counter, PC wrap, push of wrapped PC+1
    vecs.push_back(mkp(WR | PE, 5, 16'h0040, 16'h0040, 0, 1'b0));
    vecs.push_back(mkp(WR, 5, 16'hFFFF, 16'hFFFF, 0, 1'b0));
    vecs.push_back(mkp(PE, 0, 16'h0, 16'h0000, 0, 1'b0));
    vecs.push_back(mkp(WR, 5, 16'hFFFF, 16'hFFFF, 0, 1'b0));
    vecs.push_back(mkp(CL, 0, 16'h0123, 16'h0123, 1, 1'b0));
    vecs.push_back(mkp(RT, 0, 16'h0, 16'h0000, 0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard empty", 32'(sb.size()), 32'h1);
      end else begin
        e = sb.pop_front();
        check_vec(e, i);
      end
    end

    // No write bypass: old DR0 visible until the edge
    @(negedge clk);
    drive(idle);
    bus.i_wr_en = 1'b1; bus.i_wr_sel = 3'd1; bus.i_data = 16'h5555; bus.i_op0_sel = 3'd1;
    #1;
    chk("nobypass before", 32'(bus.o_operand0), 32'h1111);
    @(posedge clk);
    #1;
    chk("nobypass after", 32'(bus.o_operand0), 32'h5555);

    // Async reset with two stacked return addresses
    @(negedge clk);
    drive(idle);
    bus.i_pc_call = 1'b1; bus.i_data = 16'h0100;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.i_data = 16'h0200;
    @(posedge clk);
    #1;
    chk("pre-rst pc",  32'(bus.o_program_addr), 32'h0200);
    chk("pre-rst cnt", 32'(bus.o_stack_count), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async pc",    32'(bus.o_program_addr), 32'h0);
    chk("async cnt",   32'(bus.o_stack_count), 32'h0);
    chk("async empty", 32'(bus.o_stack_empty), 32'h1);
    chk("async ar",    32'(bus.o_direct_addr), 32'h0);
    chk("async dr0",   32'(bus.o_operand0), 32'h0);
    chk("async err",   32'(bus.o_stack_err), 32'h0);

    // First edge after release operates normally
    @(negedge clk);
    drive(idle);
    bus.i_pc_counter_en = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst pc", 32'(bus.o_program_addr), 32'h1);
    @(negedge clk);
    drive(idle);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
